// File: rtl/tree_path_walker.sv
// Path-of-identifiers lookup engine over a constant tree image.
// Identifiers arrive one per level; one child slot is scanned per cycle.
package user_tree_pkg;
  localparam int NUM_MSG_HIERARCHY   = 2;
  localparam int MAX_NODES_PER_LEVEL = 4;
  localparam int IDENTIFIER_SIZE     = 8;
  localparam int NUM_NODES           = 8;
endpackage

package tree_pkg;
  localparam int IDENTIFIER_SIZE     = user_tree_pkg::IDENTIFIER_SIZE;
  localparam int MAX_NODES_PER_LEVEL = user_tree_pkg::MAX_NODES_PER_LEVEL;
  localparam int NUM_NODES           = user_tree_pkg::NUM_NODES;
  localparam int NODE_ADDR_SIZE      = $clog2(NUM_NODES);
  localparam int NODE_SIZE           = IDENTIFIER_SIZE + MAX_NODES_PER_LEVEL*NODE_ADDR_SIZE;
  typedef logic [NUM_NODES-1:0][NODE_SIZE-1:0] tree_t;
endpackage

module tree_path_walker
  import tree_pkg::*;
#(
  parameter tree_t TREE      = '0,
  parameter int    MAX_DEPTH = user_tree_pkg::NUM_MSG_HIERARCHY
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               id_valid,
  output logic                               id_ready,
  input  logic [IDENTIFIER_SIZE-1:0]         id,
  input  logic                               id_last,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [NODE_ADDR_SIZE-1:0]          res_addr,
  output logic                               res_found,
  output logic [$clog2(MAX_DEPTH+1)-1:0]     res_depth
);
  localparam int DW = $clog2(MAX_DEPTH+1);
  localparam int KW = (MAX_NODES_PER_LEVEL > 1) ? $clog2(MAX_NODES_PER_LEVEL) : 1;
  localparam logic [DW-1:0] DMAX = DW'(MAX_DEPTH);
  localparam logic [DW-1:0] DSAT = DW'(MAX_DEPTH+1);
  localparam logic [KW-1:0] KMAX = KW'(MAX_NODES_PER_LEVEL-1);

  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, RESP} state_t;

  state_t                    state, state_n;
  logic [KW-1:0]             k, k_n;
  logic [NODE_ADDR_SIZE-1:0] cur, cur_n;
  logic [DW-1:0]             depth, depth_n, depth_inc;
  logic [IDENTIFIER_SIZE-1:0] id_q, id_n;
  logic                      last_q, last_n;
  logic                      res_valid_n, res_found_n;
  logic [NODE_ADDR_SIZE-1:0] res_addr_n;
  logic [DW-1:0]             res_depth_n;
  logic [NODE_ADDR_SIZE-1:0] child;
  logic [IDENTIFIER_SIZE-1:0] child_id;
  logic                      hs, hit, miss;

  assign id_ready  = (state == IDLE) || (state == DRAIN);
  assign hs        = id_valid && id_ready;
  assign depth_inc = (depth == DSAT) ? depth : depth + DW'(1);
  assign child     = TREE[cur][IDENTIFIER_SIZE + int'(k)*NODE_ADDR_SIZE +: NODE_ADDR_SIZE];
  assign child_id  = TREE[child][IDENTIFIER_SIZE-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      cur       <= '0;
      depth     <= '0;
      id_q      <= '0;
      last_q    <= 1'b0;
      res_valid <= 1'b0;
      res_addr  <= '0;
      res_found <= 1'b0;
      res_depth <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      cur       <= cur_n;
      depth     <= depth_n;
      id_q      <= id_n;
      last_q    <= last_n;
      res_valid <= res_valid_n;
      res_addr  <= res_addr_n;
      res_found <= res_found_n;
      res_depth <= res_depth_n;
    end
  end

  always_comb begin
    state_n     = state;
    k_n         = k;
    cur_n       = cur;
    depth_n     = depth;
    id_n        = id_q;
    last_n      = last_q;
    res_valid_n = res_valid;
    res_addr_n  = res_addr;
    res_found_n = res_found;
    res_depth_n = res_depth;
    hit         = 1'b0;
    miss        = 1'b0;
    case (state)
      IDLE: if (hs) begin
        id_n    = id;
        last_n  = id_last;
        depth_n = depth_inc;
        k_n     = '0;
        state_n = SEARCH;
      end
      SEARCH: begin
        // Slots fill from 0 upward, so the first empty slot ends the scan.
        if (id_q == '0)               miss = 1'b1;
        else if (depth > DMAX)        miss = 1'b1;
        else if (child == '0)         miss = 1'b1;
        else if (child_id == id_q)    hit  = 1'b1;
        else if (k == KMAX)           miss = 1'b1;
        else                          k_n  = k + KW'(1);
        if (hit) begin
          cur_n = child;
          if (last_q) begin
            state_n     = RESP;
            res_valid_n = 1'b1;
            res_found_n = 1'b1;
            res_addr_n  = child;
            res_depth_n = depth;
          end else begin
            state_n = IDLE;
          end
        end else if (miss) begin
          if (last_q) begin
            state_n     = RESP;
            res_valid_n = 1'b1;
            res_found_n = 1'b0;
            res_addr_n  = '0;
            res_depth_n = depth;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: if (hs) begin
        depth_n = depth_inc;
        if (id_last) begin
          state_n     = RESP;
          res_valid_n = 1'b1;
          res_found_n = 1'b0;
          res_addr_n  = '0;
          res_depth_n = depth_inc;
        end
      end
      RESP: if (res_ready) begin
        res_valid_n = 1'b0;
        depth_n     = '0;
        cur_n       = '0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
